// File: rtl/dbus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_ctrl_pkg
// Description : Shared types for the data-side bus controller. The package
//               holds the memory-access size and type encodings, the
//               controller state encoding and the latched request record.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_ctrl_pkg;

    // Widths of the latched request record. The controller's ADDR_W/DATA_W
    // parameters are expected to match these.
    localparam int DBUS_ADDR_W = 32;
    localparam int DBUS_DATA_W = 32;
    localparam int DBUS_STRB_W = DBUS_DATA_W / 8;

    // Access size as presented on the bus (bytes = 1 << encoding).
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    // Memory operation type from the decoder.
    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_type_t;

    // Controller states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } dbus_state_t;

    // Request fields held while the bus has not yet accepted the request.
    typedef struct packed {
        logic                   write;
        logic [DBUS_ADDR_W-1:0] addr;
        msize_t                 size;
        logic [DBUS_DATA_W-1:0] data;
        logic [DBUS_STRB_W-1:0] strobe;
    } dbus_req_t;

endpackage : dbus_ctrl_pkg
`default_nettype wire

// File: rtl/dbus_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load lane select and sign/zero extension.
//               Picks the byte or halfword addressed by the low address bits
//               and extends it according to the load type; word loads and
//               any non-load type pass the data through unchanged.
// Ports       : data_i      - raw bus response word
//               off_i       - byte offset within the word
//               mem_type_i  - load type (MEM_LB/LBU/LH/LHU/LW)
//               data_o      - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import dbus_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [OFF_W-1:0]  off_i,
    input  mem_type_t         mem_type_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lanes ignore the lowest offset bit (aligned halfwords).
    assign w_byte = data_i[8*off_i +: 8];
    assign w_half = data_i[16*off_i[OFF_W-1:1] +: 16];

    always_comb begin
        data_o = data_i;
        case (mem_type_i)
            MEM_LB:  data_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
            MEM_LBU: data_o = {{(DATA_W-8){1'b0}}, w_byte};
            MEM_LH:  data_o = {{(DATA_W-16){w_half[15]}}, w_half};
            MEM_LHU: data_o = {{(DATA_W-16){1'b0}}, w_half};
            default: data_o = data_i;
        endcase
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dbus_ctrl
// Description : Data-side bus controller downstream of the memory stage.
//               Issues one load/store at a time over a two-phase bus
//               handshake (addr_ok then data_ok), holds the load result for
//               the memory stage and stalls the pipeline while a transaction
//               is outstanding.
//               Optional build macro DBUS_LOAD_EXT_EN adds the mem_type input
//               and applies byte/halfword lane select and extension to load
//               data as it is captured.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               rvalid/wvalid       - load / store request from memory stage
//               addr/size/wdata/strobe - request fields
//               flush               - squash the memory-stage request
//               advance             - pipeline moves M->W this cycle
//               dreq_*              - bus request channel
//               addr_ok/data_ok/rdata - bus handshake and response
//               rd                  - held load result
//               busy                - stall request to the hazard unit
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_ctrl
    import dbus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rvalid,
    input  logic                wvalid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [2:0]          size,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] strobe,
    input  logic                flush,
    input  logic                advance,
`ifdef DBUS_LOAD_EXT_EN
    input  mem_type_t           mem_type,
`endif
    output logic                dreq_valid,
    output logic                dreq_write,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [2:0]          dreq_size,
    output logic [DATA_W-1:0]   dreq_data,
    output logic [DATA_W/8-1:0] dreq_strobe,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W-1:0]   rd,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    dbus_state_t         state_q;
    dbus_req_t           req_q;
    logic [DATA_W-1:0]   result_q;

    logic                w_req_any;
    logic                w_issue;
    logic                w_both_ok;
    logic                w_cap_is_load;
    logic [DATA_W-1:0]   w_cap_data;
    dbus_req_t           w_new_req;

    // A live request from the memory stage; a flushed one is never issued.
    assign w_req_any = (rvalid | wvalid) & ~flush;

    // Issue straight from the inputs in IDLE, or in DONE when the pipeline
    // advances with the next request already waiting (no bubble).
    assign w_issue   = w_req_any & ((state_q == S_IDLE) |
                                    ((state_q == S_DONE) & advance));
    assign w_both_ok = addr_ok & data_ok;

    // Loads carry no write data or byte enables on the bus.
    always_comb begin
        w_new_req        = '0;
        w_new_req.write  = wvalid;
        w_new_req.addr   = DBUS_ADDR_W'(addr);
        w_new_req.size   = msize_t'(size);
        w_new_req.data   = wvalid ? DBUS_DATA_W'(wdata) : '0;
        w_new_req.strobe = wvalid ? DBUS_STRB_W'(strobe) : '0;
    end

    // Capture happens either in the issue cycle (fields from the inputs)
    // or later (fields from the latched request).
    assign w_cap_is_load = w_issue ? ~wvalid : ~req_q.write;

`ifdef DBUS_LOAD_EXT_EN
    localparam int OFF_W = $clog2(STRB_W);

    mem_type_t           mem_type_q;
    logic [OFF_W-1:0]    w_cap_off;
    mem_type_t           w_cap_type;

    assign w_cap_off  = w_issue ? addr[OFF_W-1:0] : req_q.addr[OFF_W-1:0];
    assign w_cap_type = w_issue ? mem_type : mem_type_q;

    load_extend #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_extend (
        .data_i     (rdata),
        .off_i      (w_cap_off),
        .mem_type_i (w_cap_type),
        .data_o     (w_cap_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_type_q <= MEM_NONE;
        end else if (w_issue) begin
            mem_type_q <= mem_type;
        end
    end
`else
    assign w_cap_data = rdata;
`endif

    // ------------------------------------------------------------------
    // Bus request channel and stall output
    // ------------------------------------------------------------------
    always_comb begin
        dreq_valid  = 1'b0;
        dreq_write  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = '0;
        dreq_data   = '0;
        dreq_strobe = '0;
        busy        = 1'b0;

        if (!reset) begin
            if (w_issue) begin
                // Same-cycle pass-through of the memory-stage request.
                dreq_valid  = 1'b1;
                dreq_write  = w_new_req.write;
                dreq_addr   = ADDR_W'(w_new_req.addr);
                dreq_size   = w_new_req.size;
                dreq_data   = DATA_W'(w_new_req.data);
                dreq_strobe = STRB_W'(w_new_req.strobe);
            end else if (state_q == S_REQ) begin
                // Held from the register until the bus accepts it, even in
                // a flush cycle.
                dreq_valid  = 1'b1;
                dreq_write  = req_q.write;
                dreq_addr   = ADDR_W'(req_q.addr);
                dreq_size   = req_q.size;
                dreq_data   = DATA_W'(req_q.data);
                dreq_strobe = STRB_W'(req_q.strobe);
            end

            // Stall ends in the very cycle the response shows up.
            case (state_q)
                S_IDLE,
                S_DONE:  busy = w_issue & ~w_both_ok;
                S_REQ:   busy = ~w_both_ok;
                S_WAIT:  busy = ~data_ok;
                S_DRAIN: busy = (rvalid | wvalid) & ~data_ok;
                default: busy = 1'b0;
            endcase
        end
    end

    assign rd = result_q;

    // ------------------------------------------------------------------
    // Controller state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE,
                S_DONE: begin
                    if (w_issue) begin
                        req_q <= w_new_req;
                        if (w_both_ok) begin
                            if (w_cap_is_load) begin
                                result_q <= w_cap_data;
                            end
                            state_q <= S_DONE;
                        end else if (addr_ok) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end else if ((state_q == S_DONE) && (flush || advance)) begin
                        state_q <= S_IDLE;
                    end
                end

                S_REQ: begin
                    if (addr_ok) begin
                        if (flush) begin
                            // Accepted in the flush cycle: the response
                            // still has to be consumed and discarded.
                            state_q <= data_ok ? S_IDLE : S_DRAIN;
                        end else if (data_ok) begin
                            if (w_cap_is_load) begin
                                result_q <= w_cap_data;
                            end
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (flush) begin
                        state_q <= S_IDLE;
                    end
                end

                S_WAIT: begin
                    if (data_ok) begin
                        if (flush) begin
                            state_q <= S_IDLE;
                        end else begin
                            if (w_cap_is_load) begin
                                result_q <= w_cap_data;
                            end
                            state_q <= S_DONE;
                        end
                    end else if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (data_ok) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule : dbus_ctrl
`default_nettype wire

// File: tb/tb_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_ctrl
// Description : Directed self-checking bench for dbus_ctrl. Drives the
//               memory-stage and bus handshake inputs cycle by cycle and
//               compares outputs against hand-computed values. The load
//               extension checks run when DBUS_LOAD_EXT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_ctrl;
    import dbus_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        rvalid;
    logic        wvalid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        flush;
    logic        advance;
    mem_type_t   mem_type;
    logic        dreq_valid;
    logic        dreq_write;
    logic [31:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [31:0] dreq_data;
    logic [3:0]  dreq_strobe;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic [31:0] rd;
    logic        busy;

    int n_vec;
    int n_err;
    int n_acc;
    int acc0;

    dbus_ctrl #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rvalid      (rvalid),
        .wvalid      (wvalid),
        .addr        (addr),
        .size        (size),
        .wdata       (wdata),
        .strobe      (strobe),
        .flush       (flush),
        .advance     (advance),
`ifdef DBUS_LOAD_EXT_EN
        .mem_type    (mem_type),
`endif
        .dreq_valid  (dreq_valid),
        .dreq_write  (dreq_write),
        .dreq_addr   (dreq_addr),
        .dreq_size   (dreq_size),
        .dreq_data   (dreq_data),
        .dreq_strobe (dreq_strobe),
        .addr_ok     (addr_ok),
        .data_ok     (data_ok),
        .rdata       (rdata),
        .rd          (rd),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requests accepted by the bus (valid and addr_ok at a clock edge).
    always @(posedge clk) begin
        if (reset) n_acc <= 0;
        else if (dreq_valid && addr_ok) n_acc <= n_acc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; n_acc = 0;
        reset = 1'b1; rvalid = 0; wvalid = 0; addr = '0; size = MSIZE4;
        wdata = '0; strobe = '0; flush = 0; advance = 0; mem_type = MEM_LW;
        addr_ok = 0; data_ok = 0; rdata = '0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0; #1;
        chk("rst_valid", dreq_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd", rd, 32'h0);

        // Load, accepted on issue, response three cycles later.
        rvalid = 1; addr = 32'h8000_0010; addr_ok = 1; #1;
        chk("ld_valid", dreq_valid, 1'b1);
        chk("ld_write", dreq_write, 1'b0);
        chk("ld_addr", dreq_addr, 32'h8000_0010);
        chk("ld_strobe", dreq_strobe, 4'h0);
        chk("ld_busy0", busy, 1'b1);
        step(); addr_ok = 0; #1;
        chk("ld_wait_valid", dreq_valid, 1'b0);
        chk("ld_busy1", busy, 1'b1);
        step(); #1;
        chk("ld_busy2", busy, 1'b1);
        step(); data_ok = 1; rdata = 32'hDEAD_BEEF; #1;
        chk("ld_busy3", busy, 1'b0);
        step(); data_ok = 0; rdata = '0; #1;
        chk("ld_rd", rd, 32'hDEAD_BEEF);
        chk("ld_done_busy", busy, 1'b0);
        advance = 1; rvalid = 0; step(); advance = 0;

        // Store with delayed acceptance; request must hold while in REQ.
        acc0 = n_acc;
        wvalid = 1; addr = 32'h8000_0020; wdata = 32'h0000_ABCD; strobe = 4'b0011; #1;
        chk("st_write", dreq_write, 1'b1);
        chk("st_strobe", dreq_strobe, 4'b0011);
        step(); addr = '0; wdata = 32'hFFFF_FFFF; strobe = 4'hF; #1;
        chk("st_req_valid", dreq_valid, 1'b1);
        chk("st_req_addr", dreq_addr, 32'h8000_0020);
        chk("st_req_data", dreq_data, 32'h0000_ABCD);
        chk("st_req_strobe", dreq_strobe, 4'b0011);
        step(); #1;
        chk("st_req_addr2", dreq_addr, 32'h8000_0020);
        chk("st_req_data2", dreq_data, 32'h0000_ABCD);
        addr_ok = 1; #1;
        chk("st_acc_valid", dreq_valid, 1'b1);
        step(); addr_ok = 0; data_ok = 1; rdata = 32'h5555_5555; #1;
        chk("st_resp_busy", busy, 1'b0);
        chk("st_resp_valid", dreq_valid, 1'b0);
        step(); data_ok = 0; #1;
        chk("st_rd_kept", rd, 32'hDEAD_BEEF);
        chk("st_acc_cnt", n_acc - acc0, 1);
        advance = 1; wvalid = 0; step(); advance = 0;

        // Flush while the request waits for acceptance.
        acc0 = n_acc;
        rvalid = 1; addr = 32'h8000_0030; #1;
        step(); flush = 1; #1;
        chk("fr_held_valid", dreq_valid, 1'b1);
        step(); flush = 0; rvalid = 0; #1;
        chk("fr_valid", dreq_valid, 1'b0);
        chk("fr_busy", busy, 1'b0);
        chk("fr_acc_cnt", n_acc - acc0, 0);
        // Back in IDLE: single-cycle transaction (both oks on issue).
        rvalid = 1; addr = 32'h8000_0034; addr_ok = 1; data_ok = 1; rdata = 32'h1122_3344; #1;
        chk("min_addr", dreq_addr, 32'h8000_0034);
        chk("min_busy", busy, 1'b0);
        step(); rvalid = 0; addr_ok = 0; data_ok = 0; #1;
        chk("min_rd", rd, 32'h1122_3344);
        advance = 1; step(); advance = 0;

        // Flush while waiting for the response; drain it.
        rvalid = 1; addr = 32'h8000_0040; addr_ok = 1; #1;
        step(); rvalid = 0; addr_ok = 0; flush = 1; #1;
        step(); flush = 0; #1;
        chk("dr_busy", busy, 1'b0);
        chk("dr_valid", dreq_valid, 1'b0);
        rvalid = 1; addr = 32'h8000_0050; #1;
        chk("dr_req_busy", busy, 1'b1);
        chk("dr_req_valid", dreq_valid, 1'b0);
        step(); #1;
        chk("dr_req_valid2", dreq_valid, 1'b0);
        data_ok = 1; rdata = 32'h1234_5678; #1;
        chk("dr_resp_busy", busy, 1'b0);
        step(); data_ok = 0; #1;
        chk("dr_rd_kept", rd, 32'h1122_3344);
        chk("dr_next_valid", dreq_valid, 1'b1);
        chk("dr_next_addr", dreq_addr, 32'h8000_0050);
        addr_ok = 1; data_ok = 1; rdata = 32'hCAFE_F00D; #1;
        step(); addr_ok = 0; data_ok = 0; rvalid = 0; #1;
        chk("dr_next_rd", rd, 32'hCAFE_F00D);

        // Back-to-back: new load issued in the advance cycle out of DONE.
        advance = 1; rvalid = 1; addr = 32'h8000_0060; addr_ok = 1; #1;
        chk("b2b_valid", dreq_valid, 1'b1);
        chk("b2b_addr", dreq_addr, 32'h8000_0060);
        chk("b2b_busy", busy, 1'b1);
        step(); advance = 0; rvalid = 0; addr_ok = 0; data_ok = 1; rdata = 32'h0BAD_F00D; #1;
        step(); data_ok = 0; #1;
        chk("b2b_rd", rd, 32'h0BAD_F00D);
        advance = 1; step(); advance = 0;

        // Reset in the middle of a transaction.
        rvalid = 1; addr = 32'h8000_0070; addr_ok = 1; #1;
        step(); rvalid = 0; addr_ok = 0; reset = 1; #1;
        step(); reset = 0; #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_valid", dreq_valid, 1'b0);
        chk("mrst_rd", rd, 32'h0);

`ifdef DBUS_LOAD_EXT_EN
        mem_type = MEM_LB; rvalid = 1; addr = 32'h8000_0003;
        addr_ok = 1; data_ok = 1; rdata = 32'h80FF_FFFF; #1;
        step(); #1;
        chk("ext_lb", rd, 32'hFFFF_FF80);
        advance = 1; mem_type = MEM_LHU; addr = 32'h8000_0002; #1;
        step(); advance = 0; rvalid = 0; addr_ok = 0; data_ok = 0; #1;
        chk("ext_lhu", rd, 32'h0000_80FF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dbus_ctrl
`default_nettype wire

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
- Sits directly downstream of the memory stage. Consumes its read and write requests (valid/addr/size, plus data/strobe for writes).
- Drives the data-side bus with a two-phase handshake (addr_ok, then data_ok) and returns load data as rd.
- Raises busy to the hazard unit while a transaction is outstanding. Holds the result until the pipeline advances.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, bus data width; strobe width is DATA_W/8

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- rvalid  in  1  memory-stage read request
- wvalid  in  1  memory-stage write request; rvalid and wvalid are never both 1
- addr  in  ADDR_W  request address
- size  in  3  msize_t encoding (MSIZE1/2/4)
- wdata  in  DATA_W  aligned write data
- strobe  in  DATA_W/8  byte enables for writes
- flush  in  1  exception/eret in memory stage; squash request
- advance  in  1  pipeline moves M->W this cycle
- dreq_valid  out  1  bus request valid
- dreq_write  out  1  bus request is a store
- dreq_addr  out  ADDR_W  bus address
- dreq_size  out  3  bus size
- dreq_data  out  DATA_W  bus write data
- dreq_strobe  out  DATA_W/8  bus byte enables (0 for loads)
- addr_ok  in  1  bus accepted request
- data_ok  in  1  bus response valid
- rdata  in  DATA_W  bus response data
- rd  out  DATA_W  load result to memory stage
- busy  out  1  stall request to hazard unit

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN. Reset -> IDLE, with all outputs 0 and the result register at 0.
- IDLE:
  - If (rvalid|wvalid) & ~flush: latch the request fields into the request register, assert dreq_valid in the same cycle from the inputs (combinational pass-through), and set busy=1.
  - If addr_ok is also 1 in that cycle, go to WAIT; otherwise go to REQ.
  - If flush=1, issue nothing and stay in IDLE.
- REQ:
  - dreq_* are driven from the latched register and held stable until addr_ok. busy=1.
  - addr_ok -> WAIT. If addr_ok and data_ok arrive in the same cycle, capture rdata and go to DONE.
  - flush while in REQ (request not yet accepted): drop dreq_valid next cycle and go to IDLE. A request already presented may not be withdrawn in the cycle addr_ok is seen.
- WAIT:
  - dreq_valid=0, busy=1.
  - data_ok: capture rdata into the result register (stores capture nothing) and go to DONE. busy falls to 0 in the same cycle data_ok=1, so the stall lasts exactly until the response.
  - flush in WAIT -> DRAIN.
- DONE:
  - busy=0 and rd = result register.
  - advance -> IDLE. If a new request is present in the same cycle as advance, treat it as in IDLE (back-to-back issue, no bubble).
  - flush -> IDLE with no issue.
- DRAIN:
  - busy=0 so the pipeline flushes without stalling. Wait for data_ok, discard rdata, then go to IDLE.
  - New requests arriving during DRAIN are not issued. busy=1 if such a request is present, until data_ok.
- Ordering: at most one outstanding transaction. Responses arrive in order.
- Latency:
  - Minimum 1 cycle: issue and both oks in the same cycle gives rd valid the next cycle (DONE), with busy high 0 cycles.
  - Otherwise busy is high from request until data_ok.
- Reset mid-transaction returns to IDLE. The bus side is reset simultaneously, and no drain is required.

Optional Feature:
- Macro DBUS_LOAD_EXT_EN.
- When defined:
  - Adds input mem_type (mem_type_t).
  - rd carries the byte/halfword lane selected by the latched addr[1:0], sign- or zero-extended per MEM_LB/LBU/LH/LHU. MEM_LW passes the word through unchanged.
  - The extension is applied when rdata is captured.
- When undefined: rd is raw rdata and extension is done in writeback.

Decomposition:
- Add dbus_state_t (the five states) and dbus_req_t (write, addr, size, data, strobe) to memory_pkg. Reuse msize_t/mem_type_t from common.
- One sub-module, load_extend (combinational lane select plus extension), instantiated only under DBUS_LOAD_EXT_EN.

Test Plan:
- Load, addr=0x80000010, addr_ok on issue, data_ok 3 cycles later with rdata=0xDEADBEEF -> busy high 3 cycles, rd=0xDEADBEEF in DONE, dreq_strobe=0.
- Store, strobe=4'b0011, wdata=0x0000ABCD, addr_ok delayed 2 cycles -> dreq_* stable throughout REQ, one request accepted, no rd update.
- Flush in REQ before addr_ok -> dreq_valid low next cycle, no transaction counted, state IDLE.
- Flush in WAIT, data_ok 2 cycles later with 0x12345678 -> busy=0, rd unchanged, next load is issued only after the data_ok.
- Back-to-back loads: advance in DONE with a new rvalid -> second dreq_valid in the same cycle, no idle bubble.
- With DBUS_LOAD_EXT_EN, MEM_LB at addr[1:0]=2'b11 and rdata=0x80FFFFFF -> rd=0xFFFFFF80. MEM_LHU at addr[1:0]=2'b10 -> rd=0x000080FF.
